huffman_param: RTL

- Parametrised successor of the six-symbol Huffman block.
- Accumulates a per-symbol histogram over a frame of FRAME_LEN valid samples, then builds a true Huffman tree by iterative two-minimum merging.
- Emits per-symbol codes and masks, then re-arms for the next frame (multi-frame operation).
- Sits between the pixel/symbol source and the entropy packer.

---
 rtl/huffman_pkg.sv | 38 +++
 rtl/huffman_min2.sv | 51 +++++
 rtl/huffman_param.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types and width helpers for the parametrised Huffman
// code builder.
//   state_t : frame sequencing (ACC -> LOAD -> MERGE -> OUT -> ACC)
//   node_t  : one node-table slot (merged weight, member-symbol mask, active)
// node_t is sized for the largest supported configuration (NSYM <= 16,
// CNT_W <= 16). Unused upper bits stay zero.
package huffman_pkg;

    typedef enum logic [1:0] {
        ACC,
        LOAD,
        MERGE,
        OUT
    } state_t;

    localparam int NODE_W_MAX    = 16;  // widest histogram counter supported
    localparam int NODE_MASK_MAX = 16;  // most symbols supported

    typedef struct packed {
        logic [NODE_W_MAX-1:0]    weight;
        logic [NODE_MASK_MAX-1:0] member;
        logic                     active;
    } node_t;

    // Width that holds a code length in 0..code_w.
    function automatic int len_w(input int code_w);
        return $clog2(code_w + 1);
    endfunction

    // Legal configurations: the histogram counter must hold FRAME_LEN and the
    // code field must hold the deepest possible code (NSYM-1 bits).
    function automatic bit cfg_ok(input int nsym, input int cnt_w,
                                  input int frame_len, input int code_w);
        return (cnt_w >= $clog2(frame_len + 1)) && (code_w >= nsym - 1) &&
               (nsym <= NODE_MASK_MAX) && (cnt_w <= NODE_W_MAX);
    endfunction

endpackage

// File: rtl/huffman_min2.sv
// huffman_min2: combinational two-minimum finder over the node table.
//   i_weight[NSYM] : slot weights
//   i_active       : slot active flags
//   o_min1         : active slot with smallest weight (ties -> lowest index)
//   o_min2         : smallest remaining active slot (ties -> lowest index)
//   o_found2       : at least two active slots exist (a merge is possible)
module huffman_min2
    import huffman_pkg::*;
#(
    parameter int NSYM  = 6,
    parameter int IDX_W = 3
) (
    input  logic [NODE_W_MAX-1:0] i_weight [NSYM],
    input  logic [NSYM-1:0]       i_active,
    output logic [IDX_W-1:0]      o_min1,
    output logic [IDX_W-1:0]      o_min2,
    output logic                  o_found2
);

    logic [NODE_W_MAX-1:0] w_w1;
    logic [NODE_W_MAX-1:0] w_w2;
    logic                  w_have1;
    logic                  w_have2;

    // Strict '<' keeps the first (lowest-index) slot on equal weights.
    always_comb begin
        w_w1     = '0;
        w_w2     = '0;
        w_have1  = 1'b0;
        w_have2  = 1'b0;
        o_min1   = '0;
        o_min2   = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (i_active[i] && (!w_have1 || (i_weight[i] < w_w1))) begin
                w_have1 = 1'b1;
                w_w1    = i_weight[i];
                o_min1  = IDX_W'(i);
            end
        end
        for (int i = 0; i < NSYM; i++) begin
            if (i_active[i] && (IDX_W'(i) != o_min1) &&
                (!w_have2 || (i_weight[i] < w_w2))) begin
                w_have2 = 1'b1;
                w_w2    = i_weight[i];
                o_min2  = IDX_W'(i);
            end
        end
        o_found2 = w_have1 && w_have2;
    end

endmodule

// File: rtl/huffman_param.sv
// huffman_param: per-frame symbol histogram followed by Huffman code build.
//   clk, reset (async, active low)
//   gray_valid/gray_data : symbol stream, symbols 1..NSYM, others dropped
//   busy                 : high while samples are not being accepted
//   CNT_valid/CNT        : one-cycle pulse with the frame histogram (held)
//   code_valid/HC/M      : one-cycle pulse with codes and masks (held)
//   tot_bits             : sum of cnt*len, present only with HUFF_TOTBITS_EN
// Handshake: a sample is taken on any rising edge where gray_valid=1 while
// busy=0; there is no back-pressure, samples offered while busy are lost.
module huffman_param
    import huffman_pkg::*;
#(
    parameter int NSYM      = 6,
    parameter int CNT_W     = 8,
    parameter int FRAME_LEN = 100,
    parameter int CODE_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gray_valid,
    input  logic [7:0]             gray_data,
    output logic                   busy,
    output logic                   CNT_valid,
    output logic [NSYM*CNT_W-1:0]  CNT,
    output logic                   code_valid,
    output logic [NSYM*CODE_W-1:0] HC,
    output logic [NSYM*CODE_W-1:0] M
`ifdef HUFF_TOTBITS_EN
    ,
    output logic [CNT_W+$clog2(CODE_W+1)-1:0] tot_bits
`endif
);

    localparam int IDX_W = $clog2(NSYM);
    localparam int LEN_W = len_w(CODE_W);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt   [NSYM];
    logic [CNT_W-1:0]      r_frame;
    node_t                 r_node  [NSYM];
    logic [LEN_W-1:0]      r_len   [NSYM];
    logic [CODE_W-1:0]     r_code  [NSYM];

    logic                  w_accept;
    logic [NODE_W_MAX-1:0] w_weight [NSYM];
    logic [NSYM-1:0]       w_active;
    logic [IDX_W-1:0]      w_min1;
    logic [IDX_W-1:0]      w_min2;
    logic [IDX_W-1:0]      w_lo;
    logic [IDX_W-1:0]      w_hi;
    logic                  w_found2;
    logic [LEN_W-1:0]      w_len_eff [NSYM];
    logic [CODE_W-1:0]     w_mask    [NSYM];

    assign busy     = (r_state != ACC);
    assign w_accept = (r_state == ACC) && gray_valid &&
                      (gray_data != 8'd0) && (gray_data <= 8'(NSYM));

    always_comb begin
        w_active = '0;
        for (int s = 0; s < NSYM; s++) begin
            w_weight[s] = r_node[s].weight;
            w_active[s] = r_node[s].active;
        end
    end

    huffman_min2 #(
        .NSYM  (NSYM),
        .IDX_W (IDX_W)
    ) u_min2 (
        .i_weight (w_weight),
        .i_active (w_active),
        .o_min1   (w_min1),
        .o_min2   (w_min2),
        .o_found2 (w_found2)
    );

    // The merged node always lands in the lower-indexed slot.
    assign w_lo = (w_min1 < w_min2) ? w_min1 : w_min2;
    assign w_hi = (w_min1 < w_min2) ? w_min2 : w_min1;

    // A lone nonzero symbol never gets merged, so it is given a 1-bit code 0.
    always_comb begin
        for (int s = 0; s < NSYM; s++) begin
            w_len_eff[s] = r_len[s];
            if ((r_len[s] == '0) && (CNT[s*CNT_W +: CNT_W] != '0)) begin
                w_len_eff[s] = LEN_W'(1);
            end
            w_mask[s] = (CODE_W'(1) << w_len_eff[s]) - CODE_W'(1);
        end
    end

`ifdef HUFF_TOTBITS_EN
    localparam int TOT_W = CNT_W + LEN_W;
    logic [TOT_W-1:0] w_tot;

    always_comb begin
        w_tot = '0;
        for (int s = 0; s < NSYM; s++) begin
            w_tot = w_tot + TOT_W'(CNT[s*CNT_W +: CNT_W]) * TOT_W'(w_len_eff[s]);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ACC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACC:     if (w_accept && (r_frame == CNT_W'(FRAME_LEN - 1))) w_next = LOAD;
            LOAD:    w_next = MERGE;
            MERGE:   if (!w_found2) w_next = OUT;
            OUT:     w_next = ACC;
            default: w_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame    <= '0;
            CNT_valid  <= 1'b0;
            CNT        <= '0;
            code_valid <= 1'b0;
            HC         <= '0;
            M          <= '0;
`ifdef HUFF_TOTBITS_EN
            tot_bits   <= '0;
`endif
            for (int s = 0; s < NSYM; s++) begin
                r_cnt[s]  <= '0;
                r_node[s] <= '0;
                r_len[s]  <= '0;
                r_code[s] <= '0;
            end
        end else begin
            CNT_valid  <= 1'b0;
            code_valid <= 1'b0;
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_frame <= r_frame + CNT_W'(1);
                        for (int s = 0; s < NSYM; s++) begin
                            if (gray_data == 8'(s + 1)) r_cnt[s] <= r_cnt[s] + CNT_W'(1);
                        end
                    end
                end
                LOAD: begin
                    CNT_valid <= 1'b1;
                    r_frame   <= '0;
                    for (int s = 0; s < NSYM; s++) begin
                        CNT[s*CNT_W +: CNT_W] <= r_cnt[s];
                        r_cnt[s]  <= '0;
                        r_node[s] <= '{weight: NODE_W_MAX'(r_cnt[s]),
                                       member: NODE_MASK_MAX'(1) << s,
                                       active: (r_cnt[s] != '0)};
                        r_len[s]  <= '0;
                        r_code[s] <= '0;
                    end
                end
                MERGE: begin
                    if (w_found2) begin
                        // Prepend: new bit goes above the bits already built.
                        for (int s = 0; s < NSYM; s++) begin
                            if (r_node[w_min1].member[s]) begin
                                r_code[s] <= r_code[s] | (CODE_W'(1) << r_len[s]);
                                r_len[s]  <= r_len[s] + LEN_W'(1);
                            end else if (r_node[w_min2].member[s]) begin
                                r_len[s]  <= r_len[s] + LEN_W'(1);
                            end
                        end
                        r_node[w_lo] <= '{weight: r_node[w_min1].weight + r_node[w_min2].weight,
                                         member: r_node[w_min1].member | r_node[w_min2].member,
                                         active: 1'b1};
                        r_node[w_hi].active <= 1'b0;
                    end else begin
                        code_valid <= 1'b1;
                        for (int s = 0; s < NSYM; s++) begin
                            HC[s*CODE_W +: CODE_W] <= r_code[s];
                            M[s*CODE_W +: CODE_W]  <= w_mask[s];
                        end
`ifdef HUFF_TOTBITS_EN
                        tot_bits <= w_tot;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
